// File: rtl/cci_dma_burst.sv
`default_nettype none
// ============================================================================
//  Module      : cci_dma_burst (with helper cci_dma_burst_fifo)
//  Description : Burst DMA engine for a CCI-style cacheline port. The read
//                path splits a transfer into aligned bursts, throttles them
//                against read-FIFO space and buffers the ordered responses.
//                The write path drains a write FIFO into aligned c1 bursts.
//                Optional macro CCI_DMA_BURST_STATS_EN adds the rd_cycles and
//                wr_cycles busy-cycle counters.
//  Revision    : 1.0 - initial release
// ============================================================================

module cci_dma_burst_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_push_data,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_head,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking; callers never push when full or pop when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

module cci_dma_burst #(
    parameter int ADDR_WIDTH = 42,
    parameter int DATA_WIDTH = 512,
    parameter int FIFO_DEPTH = 512,
    parameter int MAX_BURST  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // c0 read request / response
    output logic                    c0_tx_valid,
    output logic [ADDR_WIDTH-1:0]   c0_tx_addr,
    output logic [1:0]              c0_tx_cl_len,
    input  logic                    c0_tx_almfull,
    input  logic                    c0_rx_rd_valid,
    input  logic [DATA_WIDTH-1:0]   c0_rx_data,
    // c1 write request
    output logic                    c1_tx_valid,
    output logic [ADDR_WIDTH-1:0]   c1_tx_addr,
    output logic [1:0]              c1_tx_cl_len,
    output logic                    c1_tx_sop,
    output logic [DATA_WIDTH-1:0]   c1_tx_data,
    input  logic                    c1_tx_almfull,
    input  logic                    c1_empty,
    // DMA read side
    input  logic                    rd_go,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [ADDR_WIDTH:0]     rd_size,
    output logic                    rd_done,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_empty,
    // DMA write side
    input  logic                    wr_go,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [ADDR_WIDTH:0]     wr_size,
    output logic                    wr_done,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_full
`ifdef CCI_DMA_BURST_STATS_EN
    ,
    output logic [31:0]             rd_cycles,
    output logic [31:0]             wr_cycles
`endif
);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_SOP  = 2'd1,
        WR_BODY = 2'd2
    } wr_state_t;

    // Largest legal burst that fits the remaining lines and is naturally aligned.
    function automatic logic [2:0] f_burst_len(input logic [ADDR_WIDTH-1:0] addr,
                                               input logic [ADDR_WIDTH:0]   remain);
        logic [2:0] len;
        len = 3'd1;
        if ((MAX_BURST >= 4) && (remain[ADDR_WIDTH:2] != '0) && (addr[1:0] == 2'b00)) begin
            len = 3'd4;
        end else if ((MAX_BURST >= 2) && (remain[ADDR_WIDTH:1] != '0) && (addr[0] == 1'b0)) begin
            len = 3'd2;
        end
        return len;
    endfunction

    // ------------------------------------------------------------------ read
    logic [ADDR_WIDTH-1:0]  r_rd_addr;
    logic [ADDR_WIDTH:0]    r_rd_remain;
    logic [ADDR_WIDTH:0]    r_rd_left;
    logic [c_CNT_W-1:0]     r_rd_pending;
    logic [c_CNT_W-1:0]     w_rfifo_count;
    logic [2:0]             w_rd_blen;
    logic                   w_rd_accept;
    logic                   w_rd_issue;
    logic                   w_rd_push;
    logic                   w_rd_pop;
    logic [c_CNT_W-1:0]     w_rd_pend_inc;
    logic [c_CNT_W-1:0]     w_rd_pend_dec;
    logic [c_CNT_W:0]       w_rd_need;

    assign w_rd_blen   = f_burst_len(r_rd_addr, r_rd_remain);
    assign w_rd_accept = rd_go && rd_done;
    // Lines already buffered plus lines in flight plus this burst must fit the FIFO.
    assign w_rd_need   = {1'b0, r_rd_pending} + {1'b0, w_rfifo_count} + (c_CNT_W+1)'(w_rd_blen);
    assign w_rd_issue  = (r_rd_remain != '0) && !c0_tx_almfull
                         && (w_rd_need <= (c_CNT_W+1)'(FIFO_DEPTH));
    // Responses with nothing pending are stale (e.g. after a mid-transfer reset).
    assign w_rd_push   = c0_rx_rd_valid && (r_rd_pending != '0);
    assign w_rd_pop    = rd_en && !rd_empty;
    assign w_rd_pend_inc = w_rd_issue ? c_CNT_W'(w_rd_blen) : '0;
    assign w_rd_pend_dec = w_rd_push  ? c_CNT_W'(1)         : '0;

    // Read request generation and pending/left bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c0_tx_valid  <= 1'b0;
            c0_tx_addr   <= '0;
            c0_tx_cl_len <= 2'd0;
            r_rd_addr    <= '0;
            r_rd_remain  <= '0;
            r_rd_left    <= '0;
            r_rd_pending <= '0;
        end else begin
            c0_tx_valid <= 1'b0;
            if (w_rd_accept) begin
                r_rd_addr   <= rd_addr;
                r_rd_remain <= rd_size;
            end else if (w_rd_issue) begin
                c0_tx_valid  <= 1'b1;
                c0_tx_addr   <= r_rd_addr;
                c0_tx_cl_len <= 2'(w_rd_blen - 3'd1);
                r_rd_addr    <= r_rd_addr + ADDR_WIDTH'(w_rd_blen);
                r_rd_remain  <= r_rd_remain - (ADDR_WIDTH+1)'(w_rd_blen);
            end
            r_rd_pending <= r_rd_pending + w_rd_pend_inc - w_rd_pend_dec;
            if (w_rd_accept) begin
                r_rd_left <= rd_size;
            end else if (w_rd_pop) begin
                r_rd_left <= r_rd_left - (ADDR_WIDTH+1)'(1);
            end
        end
    end

    cci_dma_burst_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_rd_push),
        .i_push_data (c0_rx_data),
        .i_pop       (w_rd_pop),
        .o_head      (rd_data),
        .o_count     (w_rfifo_count)
    );

    assign rd_empty = (w_rfifo_count == '0);
    assign rd_done  = (r_rd_left == '0);

    // ----------------------------------------------------------------- write
    wr_state_t              r_wr_state;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic [ADDR_WIDTH:0]    r_wr_remain;
    logic [2:0]             r_wr_blen;
    logic [2:0]             r_wr_beat;
    logic                   r_wr_emit_d1;
    logic [c_CNT_W-1:0]     w_wfifo_count;
    logic [DATA_WIDTH-1:0]  w_wfifo_head;
    logic [2:0]             w_wr_blen;
    logic                   w_wr_accept;
    logic                   w_wr_push;
    logic                   w_wr_pop;

    assign w_wr_blen   = f_burst_len(r_wr_addr, r_wr_remain);
    assign w_wr_accept = wr_go && wr_done;
    assign w_wr_push   = wr_en && !wr_full;
    assign w_wr_pop    = ((r_wr_state == WR_SOP) || (r_wr_state == WR_BODY)) && !c1_tx_almfull;

    // Write burst FSM; r_wr_addr tracks the next line so body beats are base + index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state   <= WR_IDLE;
            r_wr_addr    <= '0;
            r_wr_remain  <= '0;
            r_wr_blen    <= 3'd1;
            r_wr_beat    <= 3'd0;
            r_wr_emit_d1 <= 1'b0;
            c1_tx_valid  <= 1'b0;
            c1_tx_sop    <= 1'b0;
            c1_tx_addr   <= '0;
            c1_tx_cl_len <= 2'd0;
            c1_tx_data   <= '0;
        end else begin
            c1_tx_valid  <= 1'b0;
            c1_tx_sop    <= 1'b0;
            r_wr_emit_d1 <= c1_tx_valid;
            case (r_wr_state)
                WR_IDLE: begin
                    if (w_wr_accept) begin
                        r_wr_addr   <= wr_addr;
                        r_wr_remain <= wr_size;
                    end else if ((r_wr_remain != '0) && (w_wfifo_count >= c_CNT_W'(w_wr_blen))) begin
                        r_wr_blen  <= w_wr_blen;
                        r_wr_state <= WR_SOP;
                    end
                end
                WR_SOP: begin
                    if (!c1_tx_almfull) begin
                        c1_tx_valid  <= 1'b1;
                        c1_tx_sop    <= 1'b1;
                        c1_tx_addr   <= r_wr_addr;
                        c1_tx_cl_len <= 2'(r_wr_blen - 3'd1);
                        c1_tx_data   <= w_wfifo_head;
                        r_wr_addr    <= r_wr_addr + ADDR_WIDTH'(1);
                        r_wr_remain  <= r_wr_remain - (ADDR_WIDTH+1)'(1);
                        r_wr_beat    <= 3'd1;
                        r_wr_state   <= (r_wr_blen > 3'd1) ? WR_BODY : WR_IDLE;
                    end
                end
                WR_BODY: begin
                    if (!c1_tx_almfull) begin
                        c1_tx_valid  <= 1'b1;
                        c1_tx_addr   <= r_wr_addr;
                        c1_tx_cl_len <= 2'(r_wr_blen - 3'd1);
                        c1_tx_data   <= w_wfifo_head;
                        r_wr_addr    <= r_wr_addr + ADDR_WIDTH'(1);
                        r_wr_remain  <= r_wr_remain - (ADDR_WIDTH+1)'(1);
                        r_wr_beat    <= r_wr_beat + 3'd1;
                        if (r_wr_beat == (r_wr_blen - 3'd1)) begin
                            r_wr_state <= WR_IDLE;
                        end
                    end
                end
                default: r_wr_state <= WR_IDLE;
            endcase
        end
    end

    cci_dma_burst_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_wr_push),
        .i_push_data (wr_data),
        .i_pop       (w_wr_pop),
        .o_head      (w_wfifo_head),
        .o_count     (w_wfifo_count)
    );

    assign wr_full = (w_wfifo_count == c_CNT_W'(FIFO_DEPTH));
    // Done only once the FSM is idle, the fabric has drained and the last beat has settled.
    assign wr_done = (r_wr_remain == '0) && (r_wr_state == WR_IDLE) && c1_empty
                     && !c1_tx_valid && !r_wr_emit_d1;

`ifdef CCI_DMA_BURST_STATS_EN
    // Saturating busy-cycle counters, restarted by each accepted go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cycles <= '0;
            wr_cycles <= '0;
        end else begin
            if (w_rd_accept) begin
                rd_cycles <= '0;
            end else if (!rd_done && (rd_cycles != '1)) begin
                rd_cycles <= rd_cycles + 32'd1;
            end
            if (w_wr_accept) begin
                wr_cycles <= '0;
            end else if (!wr_done && (wr_cycles != '1)) begin
                wr_cycles <= wr_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
